// File: rtl/fpga_cfg_pkg.sv
// Shared types and default sizing for the fabric configuration loader.
package fpga_cfg_pkg;

  localparam int CFG_W_DEF       = 224;
  localparam int N_CHAINS_DEF    = 43;
  localparam int START_DELAY_DEF = 10;
  localparam int SETTLE_DEF      = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_WAIT,
    S_LOAD,
    S_STROBE,
    S_SETTLE,
    S_ENABLE,
    S_DONE,
    S_ERR
  } state_t;

  // Counter width for values 0..v, never narrower than one bit.
  function automatic int cnt_w(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/cfg_delay_cnt.sv
// Loadable down-counter; done_o flags the final cycle of a delay.
module cfg_delay_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A delay of N is loaded as N, so the last waiting cycle sees 1.
  assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/fpga_cfg_loader.sv
// Streams one word per chain into the fabric, then settles and enables it.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CFG_W         = CFG_W_DEF,
  parameter int N_CHAINS      = N_CHAINS_DEF,
  parameter int START_DELAY   = START_DELAY_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                cfg_valid_i,
  input  logic [CFG_W-1:0]    cfg_data_i,
  input  logic                cfg_last_i,
  output logic                cfg_ready_o,
  output logic [CFG_W-1:0]    configs_in_o,
  output logic [N_CHAINS-1:0] configs_en_o,
  output logic                ff_en_o,
  output logic                rdy_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int IW = $clog2(N_CHAINS + 1);
  localparam int DLY_MAX =
    (START_DELAY > SETTLE_CYCLES) ? START_DELAY : SETTLE_CYCLES;
  localparam int DW = cnt_w(DLY_MAX);
  localparam logic [N_CHAINS-1:0] ONE = N_CHAINS'(1);

  state_t st_q, st_d;

  logic [IW-1:0]    idx_q, idx_d;
  logic [CFG_W-1:0] cin_q, cin_d;
  logic             last_q, last_d;

  logic          idle_like;
  logic          start_ok;
  logic          xfer;
  logic          at_last;
  logic          dly_done;
  logic          dly_load;
  logic          dly_en;
  logic [DW-1:0] dly_val;

  assign idle_like = (st_q == S_IDLE) || (st_q == S_DONE) ||
                     (st_q == S_ERR);
  assign start_ok  = start_i && idle_like;
  assign xfer      = cfg_valid_i && (st_q == S_LOAD);
  assign at_last   = (idx_q == IW'(N_CHAINS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) st_q <= S_IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i)
          st_d = (START_DELAY == 0) ? S_LOAD : S_PRE_WAIT;
      end
      S_PRE_WAIT: if (dly_done) st_d = S_LOAD;
      S_LOAD: begin
        if (xfer)
          st_d = (cfg_last_i && !at_last) ? S_ERR : S_STROBE;
      end
      S_STROBE: begin
        if (!at_last)
          st_d = S_LOAD;
        else if (!last_q)
          st_d = S_ERR;
        else
          st_d = (SETTLE_CYCLES == 0) ? S_ENABLE : S_SETTLE;
      end
      S_SETTLE: if (dly_done) st_d = S_ENABLE;
      S_ENABLE: st_d = S_DONE;
      default:  st_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_o  = (st_q == S_LOAD);
    configs_en_o = (st_q == S_STROBE) ? (ONE << idx_q) : '0;
    configs_in_o = cin_q;
    ff_en_o      = (st_q == S_ENABLE) || (st_q == S_DONE);
    rdy_o        = (st_q == S_DONE);
    err_o        = (st_q == S_ERR);
    busy_o       = !idle_like;
  end

  always_comb begin
    idx_d  = idx_q;
    cin_d  = cin_q;
    last_d = last_q;
    if (start_ok) begin
      idx_d  = '0;
      last_d = 1'b0;
    end else if (st_q == S_STROBE) begin
      idx_d = idx_q + IW'(1);
    end
    if (xfer) begin
      cin_d  = cfg_data_i;
      last_d = cfg_last_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      cin_q  <= '0;
      last_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cin_q  <= cin_d;
      last_q <= last_d;
    end
  end

  // One counter serves both waits; a zero delay bypasses its state.
  assign dly_load = (start_ok && (START_DELAY != 0)) ||
                    ((st_q == S_STROBE) && (st_d == S_SETTLE));
  assign dly_val  = (st_q == S_STROBE) ? DW'(SETTLE_CYCLES)
                                       : DW'(START_DELAY);
  assign dly_en   = (st_q == S_PRE_WAIT) || (st_q == S_SETTLE);

  cfg_delay_cnt #(
    .W (DW)
  ) u_dly (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .en_i       (dly_en),
    .done_o     (dly_done)
  );

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench: cycle table for the nominal load, scripted corner cases.
module tb_fpga_cfg_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       ready;
  logic [7:0] cin;
  logic [3:0] en;
  logic       ff;
  logic       rdy;
  logic       busy;
  logic       err;

  int n_vec = 0;
  int n_bad = 0;

  logic [11:0] sq[$];
  logic        rdy_seen;

  typedef struct packed {
    logic       st;
    logic       v;
    logic [7:0] d;
    logic       l;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[16];

  always #5 clk = ~clk;

  fpga_cfg_loader #(
    .CFG_W         (8),
    .N_CHAINS      (4),
    .START_DELAY   (2),
    .SETTLE_CYCLES (3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .cfg_valid_i  (valid),
    .cfg_data_i   (data),
    .cfg_last_i   (last),
    .cfg_ready_o  (ready),
    .configs_in_o (cin),
    .configs_en_o (en),
    .ff_en_o      (ff),
    .rdy_o        (rdy),
    .busy_o       (busy),
    .err_o        (err)
  );

  function automatic logic [16:0] outs();
    return {ready, en, cin, ff, rdy, busy, err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (en !== 4'h0) sq.push_back({en, cin});
    if (rdy === 1'b1) rdy_seen = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l,
                      input int gap);
    logic ok;
    ok = 1'b0;
    valid = 1'b0;
    repeat (gap) step();
    valid = 1'b1;
    data  = d;
    last  = l;
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = ready;
      step();
    end
    valid = 1'b0;
    last  = 1'b0;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: got no ready, want ready for %0h", d);
    end
  endtask

  task automatic chk_q(input string nm, input int n,
                       input logic [7:0] base, input logic [7:0] inc);
    logic [11:0] e;
    logic [11:0] a;
    chk({nm, "_cnt"}, sq.size(), n);
    for (int i = 0; i < n; i++) begin
      e = {4'b0001 << i, 8'(base + inc * i)};
      a = (i < sq.size()) ? sq[i] : 12'hxxx;
      chk($sformatf("%s_strobe%0d", nm, i), a, e);
    end
  endtask

  task automatic setv(input int i, input logic s, input logic v,
                      input logic [7:0] d, input logic l,
                      input logic r, input logic [3:0] e,
                      input logic [7:0] c, input logic f,
                      input logic y, input logic b, input logic x);
    tbl[i] = '{st: s, v: v, d: d, l: l,
               exp: {r, e, c, f, y, b, x}};
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    setv(0,  1, 0, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0, 1, 0);
    setv(1,  0, 0, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0, 1, 0);
    setv(2,  0, 0, 8'h00, 0, 1, 4'h0, 8'h00, 0, 0, 1, 0);
    setv(3,  0, 1, 8'h11, 0, 0, 4'h1, 8'h11, 0, 0, 1, 0);
    setv(4,  0, 1, 8'h22, 0, 1, 4'h0, 8'h11, 0, 0, 1, 0);
    setv(5,  0, 1, 8'h22, 0, 0, 4'h2, 8'h22, 0, 0, 1, 0);
    setv(6,  0, 1, 8'h33, 0, 1, 4'h0, 8'h22, 0, 0, 1, 0);
    setv(7,  0, 1, 8'h33, 0, 0, 4'h4, 8'h33, 0, 0, 1, 0);
    setv(8,  0, 1, 8'h44, 1, 1, 4'h0, 8'h33, 0, 0, 1, 0);
    setv(9,  0, 1, 8'h44, 1, 0, 4'h8, 8'h44, 0, 0, 1, 0);
    setv(10, 0, 0, 8'h00, 0, 0, 4'h0, 8'h44, 0, 0, 1, 0);
    setv(11, 0, 0, 8'h00, 0, 0, 4'h0, 8'h44, 0, 0, 1, 0);
    setv(12, 0, 0, 8'h00, 0, 0, 4'h0, 8'h44, 0, 0, 1, 0);
    setv(13, 0, 0, 8'h00, 0, 0, 4'h0, 8'h44, 1, 0, 1, 0);
    setv(14, 0, 0, 8'h00, 0, 0, 4'h0, 8'h44, 1, 1, 0, 0);
    setv(15, 0, 0, 8'h00, 0, 0, 4'h0, 8'h44, 1, 1, 0, 0);

    rst = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    data = 8'h00;
    last = 1'b0;
    rdy_seen = 1'b0;
    repeat (3) step();
    chk("reset_outs", outs(), 17'h0);
    start = 1'b1;
    step();
    chk("reset_ignores_start", outs(), 17'h0);
    start = 1'b0;
    rst = 1'b0;
    step();
    chk("idle_after_reset", outs(), 17'h0);

    for (int i = 0; i < 16; i++) begin
      start = tbl[i].st;
      valid = tbl[i].v;
      data  = tbl[i].d;
      last  = tbl[i].l;
      step();
      chk($sformatf("nominal_row%0d", i), outs(), tbl[i].exp);
    end
    start = 1'b0;
    valid = 1'b0;
    last  = 1'b0;

    sq.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send(8'h11 * (i + 1), i == 3, 5);
    repeat (6) step();
    chk_q("backpressure", 4, 8'h11, 8'h11);
    chk("bp_done", {ff, rdy, busy, err}, 4'b1100);

    sq.delete();
    pulse_start();
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b1, 0);
    chk("early_err", {err, ff, rdy, ready, busy}, 5'b10000);
    repeat (3) step();
    chk_q("early", 1, 8'h11, 8'h00);
    chk("early_err_held", err, 1'b1);

    sq.delete();
    rdy_seen = 1'b0;
    pulse_start();
    chk("start_clears_err", {err, busy}, 2'b01);
    for (int i = 0; i < 4; i++) send(8'h51 + i, 1'b0, 0);
    repeat (10) step();
    chk_q("missing", 4, 8'h51, 8'h01);
    chk("missing_err", {err, ff, rdy}, 3'b100);
    chk("missing_no_rdy", rdy_seen, 1'b0);

    sq.delete();
    pulse_start();
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b0, 0);
    valid = 1'b1;
    data  = 8'h33;
    step();
    step();
    valid = 1'b0;
    chk("pre_reset_strobe", {en, cin}, 12'h433);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outs", outs(), 17'h0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("post_reset_idle", {busy, ready}, 2'b00);
    sq.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send(8'h61 + i, i == 3, 0);
    repeat (6) step();
    chk_q("fresh", 4, 8'h61, 8'h01);
    chk("fresh_done", {ff, rdy, err}, 3'b110);

    sq.delete();
    pulse_start();
    chk("reload_drops", {ff, rdy, busy}, 3'b001);
    send(8'hA0, 1'b0, 0);
    step();
    pulse_start();
    chk("ignored_start", {ready, busy}, 2'b11);
    for (int i = 1; i < 4; i++) send(8'hA0 + i, i == 3, 0);
    repeat (6) step();
    chk_q("reload", 4, 8'hA0, 8'h01);
    chk("reload_done", {ff, rdy, err}, 3'b110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fpga_cfg_loader.md
FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 Parameter CFG_W, default 224, width of one configuration word.
REQ-002 Parameter N_CHAINS, default 43, number of configuration chains (one word per chain).
REQ-003 Parameter START_DELAY, default 10, idle cycles between start and the first cfg_ready.
REQ-004 Parameter SETTLE_CYCLES, default 10, cycles between the last strobe and ff_en.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
REQ-008 cfg_valid  in  1  cfg_data holds a valid word.
REQ-009 cfg_data  in  CFG_W  configuration word for the current chain.
REQ-010 cfg_last  in  1  qualifies cfg_data as the final word of the stream.
REQ-011 cfg_ready  out  1  loader accepts a word this cycle.
REQ-012 configs_in  out  CFG_W  registered word driven to all chains.
REQ-013 configs_en  out  N_CHAINS  one-hot chain write strobe.
REQ-014 ff_en  out  1  fabric flip-flop enable.
REQ-015 rdy  out  1  fabric configured and running.
REQ-016 busy  out  1  high in every state except IDLE, DONE and ERR.
REQ-017 err  out  1  stream-length error; held until the next start or reset.

Function
REQ-018 FSM states: IDLE, PRE_WAIT, LOAD, STROBE, SETTLE, ENABLE, DONE, ERR.
REQ-019 IDLE/DONE/ERR + start -> PRE_WAIT; clears ff_en, rdy, err and the word index in that same cycle.
REQ-020 PRE_WAIT lasts exactly START_DELAY cycles, then -> LOAD; START_DELAY=0 goes straight to LOAD.
REQ-021 cfg_ready = 1 only in LOAD; a transfer is cfg_valid && cfg_ready.
REQ-022 On transfer: configs_in <= cfg_data; the state goes to STROBE.
REQ-023 STROBE lasts one cycle: configs_en = one-hot(index); index increments; configs_en is all-zero in every other state.
REQ-024 configs_in changes only on a transfer, so it is stable during the whole strobe cycle.
REQ-025 After the strobe, if index == N_CHAINS the state goes to SETTLE, otherwise it returns to LOAD.
REQ-026 cfg_last on a transfer with index != N_CHAINS-1 -> strobe is suppressed and the state goes to ERR.
REQ-027 No cfg_last on the transfer with index == N_CHAINS-1 -> the strobe still occurs, then the state goes to ERR.
REQ-028 cfg_valid low in LOAD stalls indefinitely with no timeout; outputs hold.
REQ-029 SETTLE lasts exactly SETTLE_CYCLES cycles, then -> ENABLE, where ff_en <= 1.
REQ-030 rdy <= 1 exactly one cycle after ff_en rises; the state goes to DONE, where ff_en and rdy are held.
REQ-031 ERR: err = 1, ff_en = 0, rdy = 0, cfg_ready = 0.
REQ-032 start while busy is ignored.
REQ-033 Index counter width = $clog2(N_CHAINS+1); delay counter width = $clog2(max(START_DELAY,SETTLE_CYCLES)+1).

Reset
REQ-034 rst high -> IDLE immediately; configs_in = 0, configs_en = 0, ff_en = 0, rdy = 0, err = 0, cfg_ready = 0, busy = 0, all counters = 0.
REQ-035 rst asserted mid-load discards the partial stream; after release the loader waits for start.

Structure
REQ-036 Shared package fpga_cfg_pkg holds the state enum and default parameter constants.
REQ-037 One sub-module, cfg_delay_cnt (loadable down-counter with done flag), serves both PRE_WAIT and SETTLE.

Verification
Bench parameters for all scenarios: CFG_W=8, N_CHAINS=4, START_DELAY=2, SETTLE_CYCLES=3.
REQ-038 Nominal: start, words 0x11, 0x22, 0x33, 0x44 (cfg_last on 0x44), valid always high -> configs_en 0001, 0010, 0100, 1000 with configs_in matching; ff_en rises 3 cycles after the last strobe; rdy rises 1 cycle later.
REQ-039 Backpressure: cfg_valid deasserted 5 cycles between words -> identical strobe sequence; no extra strobes.
REQ-040 Early last: cfg_last on the 2nd word -> exactly one strobe (0001), then err = 1 and ff_en = 0.
REQ-041 Missing last: 4 words, none with cfg_last -> four strobes, then err = 1 and rdy never rises.
REQ-042 Reset mid-load: rst during the 3rd word -> all outputs 0 asynchronously; a fresh start then loads correctly.
REQ-043 Reload and ignored start: start in DONE drops ff_en and rdy and reloads; start during LOAD has no effect.
